qdr_arb: RTL and testbench

QDR_ARB -- requirements
Module: qdr_arb

---
 rtl/qdr_arb_pkg.sv | 47 ++++
 rtl/qdr_arb_if.sv | 43 ++++
 rtl/qdr_arb_tagfifo.sv | 54 +++++
 rtl/qdr_arb.sv | 126 ++++++++++++
 tb/tb_qdr_arb.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qdr_arb_pkg.sv
// qdr_arb_pkg -- shared constants, types and arbitration helpers for the
// QDR II+ user-port arbiter (qdr_arb, qdr_arb_if, qdr_arb_tagfifo).
package qdr_arb_pkg;

  localparam int NUM_REQ    = 2;    // requesters sharing the user port
  localparam int ADDR_WIDTH = 18;   // burst address width
  localparam int DATA_WIDTH = 144;  // 36-bit bus x BL4
  localparam int BW_WIDTH   = 16;   // byte-write enables, active low
  localparam int TAG_DEPTH  = 32;   // max outstanding reads, power of two

  localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic found;
    tag_t idx;
  } grant_t;

  // Round-robin pick: the pointer has top priority, then ascending index with wrap.
  // Scanning from the farthest offset down lets the nearest valid requester win last.
  function automatic grant_t rr_pick(input logic [NUM_REQ-1:0] valid, input tag_t ptr);
    grant_t g;
    int     i;
    g = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      i = (int'(ptr) + k) % NUM_REQ;
      if (valid[i]) begin
        g.found = 1'b1;
        g.idx   = tag_t'(i);
      end
    end
    return g;
  endfunction

  // Pointer value after granting idx.
  function automatic tag_t next_ptr(input tag_t idx);
    return tag_t'((int'(idx) + 1) % NUM_REQ);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input tag_t idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/qdr_arb_if.sv
// qdr_arb_if -- requester, controller and status signals of the QDR II+ arbiter.
// Modport slave is the arbiter's view; modport master is the environment's view.
interface qdr_arb_if;
  import qdr_arb_pkg::*;

  logic                            cal_done;
  logic [NUM_REQ-1:0]              req_wr_valid;
  logic [NUM_REQ-1:0]              req_wr_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_wr_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wr_data;
  logic [NUM_REQ*BW_WIDTH-1:0]     req_wr_bw_n;
  logic [NUM_REQ-1:0]              req_rd_valid;
  logic [NUM_REQ-1:0]              req_rd_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_rd_addr;
  logic [NUM_REQ-1:0]              rsp_rd_valid;
  logic [DATA_WIDTH-1:0]           rsp_rd_data;
  logic                            app_wr_cmd;
  logic [ADDR_WIDTH-1:0]           app_wr_addr;
  logic [DATA_WIDTH-1:0]           app_wr_data;
  logic [BW_WIDTH-1:0]             app_wr_bw_n;
  logic                            app_rd_cmd;
  logic [ADDR_WIDTH-1:0]           app_rd_addr;
  logic                            app_rd_valid;
  logic [DATA_WIDTH-1:0]           app_rd_data;
  logic                            tag_err;

  modport slave (
    input  cal_done, req_wr_valid, req_wr_addr, req_wr_data, req_wr_bw_n,
           req_rd_valid, req_rd_addr, app_rd_valid, app_rd_data,
    output req_wr_ready, req_rd_ready, rsp_rd_valid, rsp_rd_data,
           app_wr_cmd, app_wr_addr, app_wr_data, app_wr_bw_n,
           app_rd_cmd, app_rd_addr, tag_err
  );

  modport master (
    output cal_done, req_wr_valid, req_wr_addr, req_wr_data, req_wr_bw_n,
           req_rd_valid, req_rd_addr, app_rd_valid, app_rd_data,
    input  req_wr_ready, req_rd_ready, rsp_rd_valid, rsp_rd_data,
           app_wr_cmd, app_wr_addr, app_wr_data, app_wr_bw_n,
           app_rd_cmd, app_rd_addr, tag_err
  );

endinterface

// File: rtl/qdr_arb_tagfifo.sv
// qdr_arb_tagfifo -- in-order FIFO of requester indices for outstanding reads.
// The controller returns reads in issue order, so the head names the owner.
module qdr_arb_tagfifo
  import qdr_arb_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  tag_t i_push_tag,
  input  logic i_pop,
  output tag_t o_head_tag,
  output logic o_full,
  output logic o_empty
);

  tag_t             r_mem [TAG_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Tag storage write
  // NOTE: the storage array is deliberately not reset; the pointers and count
  // alone say which entries are live, which keeps it mappable to plain RAM.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_tag;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_tag = r_mem[r_rd_ptr];
  assign o_full     = (r_count == CNT_W'(TAG_DEPTH));
  assign o_empty    = (r_count == '0);

endmodule

// File: rtl/qdr_arb.sv
// qdr_arb -- round-robin arbiter sharing one QDR II+ user port between
// NUM_REQ requesters, with independent write and read arbitration and an
// in-order tag FIFO routing read returns back to their requester.
// Optional: define QDR_ARB_TAGCHK_EN to flag read returns that arrive with
// no outstanding read on the sticky tag_err output.
module qdr_arb
  import qdr_arb_pkg::*;
(
  input  logic          sys_clk,
  input  logic          sys_rst,
  qdr_arb_if.slave      bus
);

  tag_t                  r_wr_ptr;
  tag_t                  r_rd_ptr;
  logic                  r_wr_cmd;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [BW_WIDTH-1:0]   r_wr_bw_n;
  logic                  r_rd_cmd;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;

  grant_t w_wr_gnt;
  grant_t w_rd_gnt;
  logic   w_wr_acc;
  logic   w_rd_acc;
  logic   w_pop;
  logic   w_full;
  logic   w_empty;
  tag_t   w_head_tag;

  // A grant is only possible with a valid request, so found alone means valid&ready.
  // Read grants see the FIFO's current fullness; a same-cycle pop does not help.
  assign w_wr_gnt = rr_pick(bus.req_wr_valid, r_wr_ptr);
  assign w_rd_gnt = rr_pick(bus.req_rd_valid, r_rd_ptr);
  assign w_wr_acc = bus.cal_done & w_wr_gnt.found;
  assign w_rd_acc = bus.cal_done & w_rd_gnt.found & ~w_full;
  assign w_pop    = bus.app_rd_valid & ~w_empty;

  assign bus.req_wr_ready = w_wr_acc ? onehot(w_wr_gnt.idx) : '0;
  assign bus.req_rd_ready = w_rd_acc ? onehot(w_rd_gnt.idx) : '0;

  // Write port: register the accepted request as next cycle's controller command
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wr_ptr  <= '0;
      r_wr_cmd  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_bw_n <= '0;
    end else begin
      r_wr_cmd <= w_wr_acc;
      if (w_wr_acc) begin
        r_wr_ptr  <= next_ptr(w_wr_gnt.idx);
        r_wr_addr <= bus.req_wr_addr[w_wr_gnt.idx*ADDR_WIDTH +: ADDR_WIDTH];
        r_wr_data <= bus.req_wr_data[w_wr_gnt.idx*DATA_WIDTH +: DATA_WIDTH];
        r_wr_bw_n <= bus.req_wr_bw_n[w_wr_gnt.idx*BW_WIDTH +: BW_WIDTH];
      end
    end
  end

  // Read port: register the accepted request as next cycle's controller command
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_rd_ptr  <= '0;
      r_rd_cmd  <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      r_rd_cmd <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_ptr  <= next_ptr(w_rd_gnt.idx);
        r_rd_addr <= bus.req_rd_addr[w_rd_gnt.idx*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  qdr_arb_tagfifo u_tagfifo (
    .i_clk      (sys_clk),
    .i_rst      (sys_rst),
    .i_push     (w_rd_acc),
    .i_push_tag (w_rd_gnt.idx),
    .i_pop      (w_pop),
    .o_head_tag (w_head_tag),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Read return: route controller data to the requester at the FIFO head
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_pop ? onehot(w_head_tag) : '0;
      if (w_pop) r_rsp_data <= bus.app_rd_data;
    end
  end

`ifdef QDR_ARB_TAGCHK_EN
  logic r_tag_err;

  // Sticky flag for a read return with nothing outstanding
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)                             r_tag_err <= 1'b0;
    else if (bus.app_rd_valid && w_empty)    r_tag_err <= 1'b1;
  end

  assign bus.tag_err = r_tag_err;
`else
  assign bus.tag_err = 1'b0;
`endif

  assign bus.app_wr_cmd   = r_wr_cmd;
  assign bus.app_wr_addr  = r_wr_addr;
  assign bus.app_wr_data  = r_wr_data;
  assign bus.app_wr_bw_n  = r_wr_bw_n;
  assign bus.app_rd_cmd   = r_rd_cmd;
  assign bus.app_rd_addr  = r_rd_addr;
  assign bus.rsp_rd_valid = r_rsp_valid;
  assign bus.rsp_rd_data  = r_rsp_data;

endmodule

// File: tb/tb_qdr_arb.sv
// tb_qdr_arb -- scoreboard bench for qdr_arb. A driver applies one cycle of
// stimulus at a time, predicts readies from a round-robin/queue model and
// pushes the expected controller commands and read responses; a monitor pops
// and compares them on the falling edge.
module tb_qdr_arb;
  import qdr_arb_pkg::*;

  logic sys_clk = 1'b0;
  logic sys_rst;

  qdr_arb_if bus();

  qdr_arb dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int                    cyc;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [BW_WIDTH-1:0]   bw;
  } wr_exp_t;

  typedef struct {
    int                    cyc;
    logic [ADDR_WIDTH-1:0] addr;
  } rd_exp_t;

  typedef struct {
    int                    cyc;
    int                    tag;
    logic [DATA_WIDTH-1:0] data;
  } rsp_exp_t;

  wr_exp_t  wr_q[$];
  rd_exp_t  rd_q[$];
  rsp_exp_t rsp_q[$];

  // Reference model state: grant pointers, outstanding read owners, tag_err onset.
  int m_wr_ptr = 0;
  int m_rd_ptr = 0;
  int m_tags[$];
  int err_cyc  = 32'h7fffffff;

  logic [ADDR_WIDTH-1:0] s_wr_addr [NUM_REQ];
  logic [DATA_WIDTH-1:0] s_wr_data [NUM_REQ];
  logic [BW_WIDTH-1:0]   s_bw      [NUM_REQ];
  logic [ADDR_WIDTH-1:0] s_rd_addr [NUM_REQ];
  logic [DATA_WIDTH-1:0] s_ret_data;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (ptr + k) % NUM_REQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic rand_payload();
    for (int i = 0; i < NUM_REQ; i++) begin
      s_wr_addr[i] = ADDR_WIDTH'($urandom);
      s_rd_addr[i] = ADDR_WIDTH'($urandom);
      s_wr_data[i] = DATA_WIDTH'({$urandom, $urandom, $urandom, $urandom, $urandom});
      s_bw[i]      = BW_WIDTH'($urandom);
    end
    s_ret_data = DATA_WIDTH'({$urandom, $urandom, $urandom, $urandom, $urandom});
  endtask

  // One cycle of stimulus: drive, predict, compare readies, record expectations.
  task automatic drive_cycle(input logic [NUM_REQ-1:0] wv, input logic [NUM_REQ-1:0] rv,
                             input logic cal, input logic ret);
    int gw;
    int gr;
    int tag;
    logic [NUM_REQ-1:0] exp_wr;
    logic [NUM_REQ-1:0] exp_rd;
    @(posedge sys_clk);
    #1;
    bus.cal_done     = cal;
    bus.req_wr_valid = wv;
    bus.req_rd_valid = rv;
    bus.app_rd_valid = ret;
    bus.app_rd_data  = s_ret_data;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = s_wr_addr[i];
      bus.req_wr_data[i*DATA_WIDTH +: DATA_WIDTH] = s_wr_data[i];
      bus.req_wr_bw_n[i*BW_WIDTH +: BW_WIDTH]     = s_bw[i];
      bus.req_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = s_rd_addr[i];
    end
    gw = cal ? model_pick(wv, m_wr_ptr) : -1;
    gr = (cal && m_tags.size() < TAG_DEPTH) ? model_pick(rv, m_rd_ptr) : -1;
    exp_wr = (gw >= 0) ? NUM_REQ'(1) << gw : '0;
    exp_rd = (gr >= 0) ? NUM_REQ'(1) << gr : '0;
    #1;
    check("wr_ready", bus.req_wr_ready, exp_wr);
    check("rd_ready", bus.req_rd_ready, exp_rd);
    if (gw >= 0) begin
      wr_q.push_back('{cyc + 1, s_wr_addr[gw], s_wr_data[gw], s_bw[gw]});
      m_wr_ptr = (gw + 1) % NUM_REQ;
    end
    if (ret) begin
      if (m_tags.size() > 0) begin
        tag = m_tags.pop_front();
        rsp_q.push_back('{cyc + 1, tag, s_ret_data});
      end else if (err_cyc > cyc + 1) begin
        err_cyc = cyc + 1;
      end
    end
    if (gr >= 0) begin
      rd_q.push_back('{cyc + 1, s_rd_addr[gr]});
      m_tags.push_back(gr);
      m_rd_ptr = (gr + 1) % NUM_REQ;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_app_wr_cmd",  bus.app_wr_cmd, 0);
    check("rst_app_rd_cmd",  bus.app_rd_cmd, 0);
    check("rst_wr_payload",  {bus.app_wr_addr, bus.app_wr_data, bus.app_wr_bw_n}, 0);
    check("rst_rd_addr",     bus.app_rd_addr, 0);
    check("rst_rsp_valid",   bus.rsp_rd_valid, 0);
    check("rst_rsp_data",    bus.rsp_rd_data, 0);
    check("rst_tag_err",     bus.tag_err, 0);
    check("rst_ready",       {bus.req_wr_ready, bus.req_rd_ready}, 0);
  endtask

  // Monitor: compare registered outputs against the scoreboard each falling edge.
  wr_exp_t  mon_w;
  rd_exp_t  mon_r;
  rsp_exp_t mon_s;
  logic     exp_err;

  initial begin
    forever begin
      @(negedge sys_clk);
      if (sys_rst === 1'b0) begin
        if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
          mon_w = wr_q.pop_front();
          check("app_wr_cmd", bus.app_wr_cmd, 1);
          check("app_wr_payload", {bus.app_wr_addr, bus.app_wr_data, bus.app_wr_bw_n},
                {mon_w.addr, mon_w.data, mon_w.bw});
        end else begin
          check("app_wr_idle", bus.app_wr_cmd, 0);
        end
        if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
          mon_r = rd_q.pop_front();
          check("app_rd_cmd", bus.app_rd_cmd, 1);
          check("app_rd_addr", bus.app_rd_addr, mon_r.addr);
        end else begin
          check("app_rd_idle", bus.app_rd_cmd, 0);
        end
        if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
          mon_s = rsp_q.pop_front();
          check("rsp_rd_valid", bus.rsp_rd_valid, NUM_REQ'(1) << mon_s.tag);
          check("rsp_rd_data", bus.rsp_rd_data, mon_s.data);
        end else begin
          check("rsp_idle", bus.rsp_rd_valid, 0);
        end
`ifdef QDR_ARB_TAGCHK_EN
        exp_err = (cyc >= err_cyc);
`else
        exp_err = 1'b0;
`endif
        check("tag_err", bus.tag_err, exp_err);
      end
    end
  end

  initial begin
    int guard;
    sys_rst          = 1'b1;
    bus.cal_done     = 1'b0;
    bus.req_wr_valid = '0;
    bus.req_rd_valid = '0;
    bus.req_wr_addr  = '0;
    bus.req_wr_data  = '0;
    bus.req_wr_bw_n  = '0;
    bus.req_rd_addr  = '0;
    bus.app_rd_valid = 1'b0;
    bus.app_rd_data  = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    check_reset_outputs();
    @(negedge sys_clk);
    #2 sys_rst = 1'b0;

    // Calibration pending: no grants; then writes alternate 0,1,0,1.
    rand_payload();
    repeat (10) drive_cycle(2'b11, 2'b00, 1'b0, 1'b0);
    repeat (4) begin
      rand_payload();
      drive_cycle(2'b11, 2'b00, 1'b1, 1'b0);
    end

    // Lone requester 1 write to 0x00010.
    rand_payload();
    s_wr_addr[1] = 18'h00010;
    drive_cycle(2'b10, 2'b00, 1'b1, 1'b0);

    // Requester 0 reads, requester 1 reads, two returns route 01 then 10.
    rand_payload();
    drive_cycle(2'b00, 2'b01, 1'b1, 1'b0);
    rand_payload();
    drive_cycle(2'b00, 2'b10, 1'b1, 1'b0);
    rand_payload();
    drive_cycle(2'b00, 2'b00, 1'b1, 1'b1);
    rand_payload();
    drive_cycle(2'b00, 2'b00, 1'b1, 1'b1);

    // Fill the tag FIFO, then one return unblocks reads only the cycle after.
    guard = 0;
    while (m_tags.size() < TAG_DEPTH && guard < 200) begin
      rand_payload();
      drive_cycle(2'b00, NUM_REQ'($urandom_range(1, 3)), 1'b1, 1'b0);
      guard++;
    end
    rand_payload();
    drive_cycle(2'b00, 2'b11, 1'b1, 1'b0);
    rand_payload();
    drive_cycle(2'b00, 2'b11, 1'b1, 1'b1);
    rand_payload();
    drive_cycle(2'b00, 2'b11, 1'b1, 1'b0);
    guard = 0;
    while (m_tags.size() > 0 && guard < 100) begin
      rand_payload();
      drive_cycle(2'b00, 2'b00, 1'b1, 1'b1);
      guard++;
    end

    // Return with nothing outstanding.
    rand_payload();
    drive_cycle(2'b00, 2'b00, 1'b1, 1'b1);
    drive_cycle(2'b00, 2'b00, 1'b1, 1'b0);
    drive_cycle(2'b00, 2'b00, 1'b1, 1'b0);

    // Randomized traffic, including calibration drops and stray returns.
    for (int n = 0; n < 400; n++) begin
      rand_payload();
      drive_cycle(NUM_REQ'($urandom), NUM_REQ'($urandom), ($urandom % 8) != 0,
                  ($urandom % 3) == 0);
    end
    guard = 0;
    while (m_tags.size() > 0 && guard < 100) begin
      rand_payload();
      drive_cycle(2'b00, 2'b00, 1'b1, 1'b1);
      guard++;
    end

    // Reset with five reads outstanding.
    for (int n = 0; n < 5; n++) begin
      rand_payload();
      drive_cycle(2'b00, NUM_REQ'(1) << $urandom_range(0, NUM_REQ - 1), 1'b1, 1'b0);
    end
    repeat (3) drive_cycle(2'b00, 2'b00, 1'b1, 1'b0);
    @(negedge sys_clk);
    #2 sys_rst = 1'b1;
    #1;
    check_reset_outputs();
    m_tags.delete();
    wr_q.delete();
    rd_q.delete();
    rsp_q.delete();
    m_wr_ptr = 0;
    m_rd_ptr = 0;
    err_cyc  = 32'h7fffffff;
    @(negedge sys_clk);
    #2 sys_rst = 1'b0;

    // First post-reset grants start from requester 0; stray return after reset
    // finds the FIFO empty.
    rand_payload();
    drive_cycle(2'b11, 2'b11, 1'b1, 1'b0);
    rand_payload();
    drive_cycle(2'b11, 2'b11, 1'b1, 1'b0);
    guard = 0;
    while (m_tags.size() > 0 && guard < 100) begin
      rand_payload();
      drive_cycle(2'b00, 2'b00, 1'b1, 1'b1);
      guard++;
    end
    rand_payload();
    drive_cycle(2'b00, 2'b00, 1'b1, 1'b1);
    repeat (4) drive_cycle(2'b00, 2'b00, 1'b1, 1'b0);
    @(negedge sys_clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
